// File: rtl/program_memory_pkg.sv
// Shared types and constants for the program memory boot loader.
// Holds the loader state encoding, the count header length and the word-size helper.
package program_memory_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        DONE   = 2'd3
    } load_state_t;

    localparam int LOAD_HEADER_BYTES = 4;

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/program_memory_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Array contents are never reset; only the read register clears on reset.
module program_memory_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read register holds its value when no read is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/program_memory_loader.sv
// Instruction store with a byte-stream boot loader: 4-byte LE word count, then LE words
// written from address 0. The fetch port is open only while the loader is idle.
module program_memory_loader
    import program_memory_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [7:0]            load_byte,
    output logic                  load_ready,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   load_word_count,
    input  logic                  fetch_enable,
    input  logic [ADDR_WIDTH-1:0] fetch_address,
    output logic                  fetch_ready,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_valid,
    output load_state_t           o_dbg_state
);

    localparam int BPW = bytes_per_word(DATA_WIDTH);
    localparam int BCW = (BPW > LOAD_HEADER_BYTES) ? $clog2(BPW) : $clog2(LOAD_HEADER_BYTES);
    localparam logic [BCW-1:0] LAST_HDR_BYTE  = BCW'(LOAD_HEADER_BYTES - 1);
    localparam logic [BCW-1:0] LAST_WORD_BYTE = BCW'(BPW - 1);
    localparam logic [32:0]    DEPTH_L        = 33'(1) << ADDR_WIDTH;

    load_state_t           r_state;
    logic [BCW-1:0]        r_byte_cnt;
    logic [31:0]           r_count;
    logic [31:0]           r_ptr;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_error;
    logic [ADDR_WIDTH:0]   r_word_count;
    logic                  r_fetch_valid;

    logic                  w_accept;
    logic [31:0]           w_count_next;
    logic [31:0]           w_ptr_next;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_word_last;
    logic                  w_in_range;
    logic                  w_wr_en;
    logic                  w_fetch_accept;

    // Handshakes: a byte transfers when load_valid && load_ready, a fetch when
    // fetch_enable && fetch_ready; load_start in the same cycle drops the byte.
    assign load_ready  = (r_state == HEADER) || (r_state == DATA);
    assign load_busy   = (r_state != IDLE);
    assign load_done   = (r_state == DONE);
    assign fetch_ready = (r_state == IDLE);
    assign load_error  = r_error;
    assign load_word_count = r_word_count;
    assign fetch_valid = r_fetch_valid;
    assign o_dbg_state = r_state;

    assign w_accept       = load_valid && load_ready && !load_start;
    assign w_count_next   = {load_byte, r_count[31:8]};
    assign w_ptr_next     = r_ptr + 32'd1;
    assign w_word_last    = (r_state == DATA) && w_accept && (r_byte_cnt == LAST_WORD_BYTE);
    assign w_in_range     = ({1'b0, r_ptr} < DEPTH_L);
    assign w_wr_en        = w_word_last && w_in_range;
    assign w_fetch_accept = fetch_enable && fetch_ready;

    always_comb begin
        w_word = r_word;
        w_word[{r_byte_cnt, 3'b000} +: 8] = load_byte;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_byte_cnt   <= '0;
            r_count      <= '0;
            r_ptr        <= '0;
            r_word       <= '0;
            r_error      <= 1'b0;
            r_word_count <= '0;
        end else if (load_start) begin
            r_state      <= HEADER;
            r_byte_cnt   <= '0;
            r_count      <= '0;
            r_ptr        <= '0;
            r_error      <= 1'b0;
            r_word_count <= '0;
        end else begin
            case (r_state)
                HEADER: begin
                    if (w_accept) begin
                        r_count <= w_count_next;
                        if (r_byte_cnt == LAST_HDR_BYTE) begin
                            r_byte_cnt <= '0;
                            if (w_count_next == 32'd0) begin
                                r_state <= DONE;
                            end else begin
                                if ({1'b0, w_count_next} > DEPTH_L) begin
                                    r_error <= 1'b1;
                                end
                                r_state <= DATA;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        r_word <= w_word;
                        if (w_word_last) begin
                            r_byte_cnt <= '0;
                            r_ptr      <= w_ptr_next;
                            // Out-of-range words are consumed but not counted.
                            if (w_in_range) begin
                                r_word_count <= r_word_count + 1'b1;
                            end
                            if (w_ptr_next == r_count) begin
                                r_state <= DONE;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_valid <= 1'b0;
        end else begin
            r_fetch_valid <= w_fetch_accept;
        end
    end

    program_memory_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst       (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_ptr[ADDR_WIDTH-1:0]),
        .i_wr_data (w_word),
        .i_rd_en   (w_fetch_accept),
        .i_rd_addr (fetch_address),
        .o_rd_data (fetch_data)
    );

endmodule
